// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction prefetch front end.
// fetch_entry_t is the queue entry layout for a 32-bit core; wider cores pack {pc, inst} the same way.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order queue of fetched {pc, inst} entries with single-cycle flush.
// The head entry is read combinationally so a pushed entry is visible the next cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        data_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  output logic [WIDTH-1:0]        head_o,
  output logic                    empty_o,
  output logic [cnt_w(DEPTH)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // DEPTH is a power of two, so pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch front end: credit-limited sequential fetch, in-order queue,
// and redirect handling that flushes the queue and drops in-flight responses.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect_i,
  input  logic [XLEN-1:0]         redirect_pc_i,
  output logic                    imem_req_o,
  output logic [XLEN-1:0]         imem_addr_o,
  input  logic                    imem_gnt_i,
  input  logic                    imem_rvalid_i,
  input  logic [31:0]             imem_rdata_i,
  output logic                    inst_valid_o,
  output logic [31:0]             inst_o,
  output logic [XLEN-1:0]         pc_o,
  input  logic                    inst_ready_i,
  output logic [cnt_w(DEPTH)-1:0] count_o
);

  localparam int            CW      = cnt_w(DEPTH);
  localparam int            EW      = XLEN + 32;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_N = CW'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit;
  logic [XLEN-1:0] redirect_target;
  logic [EW-1:0]   head;
  logic            fifo_empty;
  logic            issue;
  logic            keep;
  logic            pop;

  assign redirect_target = {redirect_pc_i[XLEN-1:2], 2'b00};

  // Entries queued plus responses still to be kept must leave room for every new request.
  assign credit     = {1'b0, fifo_count} + {1'b0, out_q} - {1'b0, drop_q};
  assign imem_req_o = !rst && (credit < DEPTH_C) && (out_q < DEPTH_N);
  assign imem_addr_o = fetch_pc_q;

  assign issue = imem_req_o && imem_gnt_i;
  assign keep  = imem_rvalid_i && (drop_q == '0) && !redirect_i;
  assign pop   = inst_valid_o && inst_ready_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    out_d      = out_q + CW'(issue) - CW'(imem_rvalid_i);
    if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (imem_rvalid_i && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (keep) resp_pc_d = resp_pc_q + XLEN'(4);
    // Everything still in flight after a redirect edge belongs to the old path.
    if (redirect_i) begin
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      drop_d     = out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (keep),
    .data_i  ({resp_pc_q, imem_rdata_i}),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .head_o  (head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign inst_valid_o = !fifo_empty;
  assign inst_o       = fifo_empty ? NOP_INST : head[31:0];
  assign pc_o         = fifo_empty ? '0 : head[EW-1:32];
  assign count_o      = fifo_count;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed and randomised bench for fetch_prefetch_queue with an in-order memory model
// and a scoreboard of expected {pc, inst} pairs in program order.
module tb_fetch_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_ready_i;
  logic [2:0]  count_o;

  fetch_prefetch_queue #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .inst_ready_i  (inst_ready_i),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  req_t        inflight[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          pops = 0;
  int          lat = 1;
  bit          lat_rand = 0;
  bit          gnt_rand = 0;
  bit          ready_rand = 0;
  bit          ready_v = 1;
  bit          rst_v = 1;
  bit          redir_v = 0;
  bit          armed = 0;
  logic [31:0] redir_pc_v = '0;
  logic [31:0] model_pc = RESET_PC;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock edge: drive inputs on the falling edge, update models, return just after the rising edge.
  task automatic tick();
    req_t r;
    exp_t e;
    int   due;
    @(negedge clk);
    if (armed) begin
      check("count_le_depth", (count_o <= 3'(DEPTH)) ? 64'd1 : 64'd0, 64'd1);
      if (!inst_valid_o) begin
        check("empty_inst_nop", inst_o, NOP);
        check("empty_pc_zero", pc_o, 0);
      end
    end
    rst           = rst_v;
    redirect_i    = redir_v;
    redirect_pc_i = redir_pc_v;
    inst_ready_i  = ready_rand ? ($urandom_range(0, 3) != 0) : ready_v;
    imem_gnt_i    = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (!rst_v && inflight.size() > 0 && inflight[0].due <= cyc + 1) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = memf(inflight[0].addr);
      void'(inflight.pop_front());
    end
    #1;
    if (rst_v) begin
      inflight.delete();
      exp_q.delete();
      model_pc = RESET_PC;
      last_due = 0;
    end else begin
      if (inst_valid_o && inst_ready_i) begin
        pops++;
        check("pop_has_expected", (exp_q.size() != 0) ? 64'd1 : 64'd0, 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pop_pc", pc_o, e.pc);
          check("pop_inst", inst_o, e.inst);
        end
      end
      if (imem_req_o && imem_gnt_i) begin
        check("issue_addr", imem_addr_o, model_pc);
        due = cyc + 1 + (lat_rand ? int'($urandom_range(1, 4)) : lat);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        r.addr = imem_addr_o;
        r.due  = due;
        inflight.push_back(r);
        e.pc   = model_pc;
        e.inst = memf(model_pc);
        exp_q.push_back(e);
        model_pc = model_pc + 32'd4;
      end
      if (redir_v) begin
        exp_q.delete();
        model_pc = {redir_pc_v[31:2], 2'b00};
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!inst_valid_o && n < 30) begin
      tick();
      n++;
    end
    check(tag, inst_valid_o, 1);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    logic [31:0] aligned;
    aligned    = {target[31:2], 2'b00};
    redir_v    = 1'b1;
    redir_pc_v = target;
    tick();
    redir_v = 1'b0;
    check("redir_valid_low", inst_valid_o, 0);
    check("redir_count_zero", count_o, 0);
    check("redir_addr", imem_addr_o, aligned);
    $display("redirect to %h at cycle %0d", target, cyc);
  endtask

  initial begin
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; inst_ready_i = 1'b0;

    repeat (2) tick();
    check("reset_valid", inst_valid_o, 0);
    check("reset_inst", inst_o, NOP);
    check("reset_pc", pc_o, 0);
    check("reset_count", count_o, 0);
    check("reset_req", imem_req_o, 0);
    check("reset_addr", imem_addr_o, RESET_PC);

    // Streaming with single-cycle memory.
    rst_v = 0;
    armed = 1;
    tick();
    check("first_valid_low", inst_valid_o, 0);
    tick();
    check("first_valid_high", inst_valid_o, 1);
    check("first_pc", pc_o, RESET_PC);
    check("first_inst", inst_o, memf(RESET_PC));
    begin
      int p0;
      p0 = pops;
      repeat (20) tick();
      check("throughput", pops - p0, 20);
      $display("stream: %0d pops in 20 cycles", pops - p0);
    end

    // Decode stall fills the queue and stops fetch.
    ready_v = 0;
    repeat (10) tick();
    check("stall_count_full", count_o, DEPTH);
    check("stall_req_low", imem_req_o, 0);
    ready_v = 1;
    repeat (12) tick();

    // Long latency, redirect with requests in flight.
    lat = 3;
    repeat (8) tick();
    do_redirect(32'h0000_0100);
    wait_valid("redir100_wait");
    check("redir100_pc", pc_o, 32'h100);
    check("redir100_inst", inst_o, memf(32'h100));

    // Redirect coinciding with a response and a grant.
    lat = 1;
    repeat (6) tick();
    do_redirect(32'h0000_0180);
    tick();
    check("redir_rv_stale_dropped", inst_valid_o, 0);
    wait_valid("redir180_wait");
    check("redir180_pc", pc_o, 32'h180);

    // Unaligned target, then address wrap.
    do_redirect(32'h0000_0203);
    wait_valid("redir203_wait");
    check("redir203_pc", pc_o, 32'h200);
    do_redirect(32'hFFFF_FFF8);
    repeat (8) tick();

    // Randomised grant, ready, latency and redirects.
    gnt_rand = 1; ready_rand = 1; lat_rand = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        redir_v    = 1'b1;
        redir_pc_v = $urandom;
      end
      tick();
      redir_v = 1'b0;
    end
    gnt_rand = 0; ready_rand = 0; lat_rand = 0; lat = 1;
    $display("random phase done at cycle %0d, pops %0d", cyc, pops);

    // Reset with a full queue.
    ready_v = 0;
    repeat (10) tick();
    check("prereset_count_full", count_o, DEPTH);
    rst_v = 1;
    tick();
    check("midreset_valid", inst_valid_o, 0);
    check("midreset_inst", inst_o, NOP);
    check("midreset_pc", pc_o, 0);
    check("midreset_count", count_o, 0);
    check("midreset_req", imem_req_o, 0);
    check("midreset_addr", imem_addr_o, RESET_PC);
    rst_v = 0;
    ready_v = 1;
    tick();
    wait_valid("restart_wait");
    check("restart_pc", pc_o, RESET_PC);
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
